// File: rtl/mult_div_unit.sv
// mult_div_unit -- multi-cycle multiply/divide unit owning the HI/LO registers.
//
// mult/multu/div/divu latch their operands, hold E_MDUBusy for MULT_CYCLES or
// DIV_CYCLES cycles, then write HI/LO on the edge that drops busy. mthi/mtlo
// write HI/LO directly while idle. mfhi/mflo are served combinationally on
// E_MDUOut.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   E_MDUA      forwarded rs operand
//   E_MDUB      forwarded rt operand
//   E_MDUOp     0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo,
//               7 mthi, 8 mtlo (9-15 none)
//   E_MDUStart  single-cycle qualifier for ops 1-4
//   E_MDUBusy   high while an operation is in progress (registered)
//   E_MDUOut    HI for mfhi, LO for mflo, else 0
//   E_HI, E_LO  architectural HI/LO registers
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDUA,
    input  logic [31:0] E_MDUB,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_MDUStart,
    output logic        E_MDUBusy,
    output logic [31:0] E_MDUOut,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q, b_q;
    logic [3:0]    op_q;

    // Result datapath, driven only from the latched operands.
    logic               b_zero;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [32:0] sa, sb, sq, sr;
    logic [31:0]        bu, uq, ur;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;
    logic               unused_bits;

    always_comb begin
        b_zero = (b_q == 32'd0);
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        // 33-bit signed divide so 0x80000000 / -1 yields 2^31, which truncates
        // to 0x80000000 with a zero remainder instead of overflowing.
        sa = $signed({a_q[31], a_q});
        sb = b_zero ? 33'sd1 : $signed({b_q[31], b_q});
        sq = sa / sb;
        sr = sa % sb;
        // Substitute divisor 1 on zero: the result is discarded anyway, this
        // just keeps the divider free of undefined values.
        bu = b_zero ? 32'd1 : b_q;
        uq = a_q / bu;
        ur = a_q % bu;

        res_hi = E_HI;
        res_lo = E_LO;
        res_wr = 1'b0;
        case (op_q)
            4'd1: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_wr = 1'b1; end
            4'd2: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_wr = 1'b1; end
            4'd3: begin res_hi = sr[31:0];      res_lo = sq[31:0];     res_wr = !b_zero; end
            4'd4: begin res_hi = ur;            res_lo = uq;           res_wr = !b_zero; end
            default: ;
        endcase
        unused_bits = &{1'b0, sq[32], sr[32]};
    end

    always_comb begin
        case (E_MDUOp)
            4'd5:    E_MDUOut = E_HI;
            4'd6:    E_MDUOut = E_LO;
            default: E_MDUOut = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            E_MDUBusy <= 1'b0;
            E_HI      <= '0;
            E_LO      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (E_MDUStart && E_MDUOp >= 4'd1 && E_MDUOp <= 4'd4) begin
                        a_q       <= E_MDUA;
                        b_q       <= E_MDUB;
                        op_q      <= E_MDUOp;
                        cnt       <= (E_MDUOp <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        state     <= BUSY;
                        E_MDUBusy <= 1'b1;
                    end else if (E_MDUOp == 4'd7) begin
                        E_HI <= E_MDUA;
                    end else if (E_MDUOp == 4'd8) begin
                        E_LO <= E_MDUA;
                    end
                end
                BUSY: begin
                    // Count was loaded with N at the start edge; the write
                    // lands N edges later, so busy spans exactly N cycles.
                    if (cnt == CW'(1)) begin
                        if (res_wr) begin
                            E_HI <= res_hi;
                            E_LO <= res_lo;
                        end
                        cnt       <= '0;
                        state     <= IDLE;
                        E_MDUBusy <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [3:0]  op = '0;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] out, hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {logic [31:0] hi; logic [31:0] lo;} exp_t;
    exp_t        sb_q[$];
    logic [31:0] m_hi = '0, m_lo = '0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_MDUA(a), .E_MDUB(b), .E_MDUOp(op),
        .E_MDUStart(start), .E_MDUBusy(busy), .E_MDUOut(out), .E_HI(hi), .E_LO(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t r;
        logic signed [31:0] xs, ys;
        longint sx, sy;
        longint unsigned ux, uy, p;
        r.hi = m_hi; r.lo = m_lo;
        xs = x; ys = y; sx = xs; sy = ys;
        ux = {32'd0, x}; uy = {32'd0, y};
        case (o)
            4'd1: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
            4'd2: begin p = ux * uy; r.hi = p[63:32]; r.lo = p[31:0]; end
            4'd3: if (y != 0) begin p = sx / sy; r.lo = p[31:0]; p = sx % sy; r.hi = p[31:0]; end
            4'd4: if (y != 0) begin p = ux / uy; r.lo = p[31:0]; p = ux % uy; r.hi = p[31:0]; end
            default: ;
        endcase
        return r;
    endfunction

    // Drive a start for one edge and push the model's expected HI/LO.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        op = o; a = x; b = y; start = 1'b1;
        e = model(o, x, y);
        sb_q.push_back(e);
        m_hi = e.hi; m_lo = e.lo;
        tick();
        start = 1'b0; op = 4'd0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL issue_busy op=%0d got %b exp 1", o, busy); end
    endtask

    // Count busy cycles (bounded) and pop the matching expected result.
    task automatic wait_done(output int n, output exp_t e);
        n = 0;
        while (busy === 1'b1 && n < 200) begin n++; tick(); end
        e.hi = 'x; e.lo = 'x;
        if (sb_q.size() > 0) e = sb_q.pop_front();
    endtask

    task automatic test_reset;
        op = 4'd5;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (hi !== 32'd0)  begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'd0)  begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
        checks++; if (out !== 32'd0) begin errors++; $display("FAIL reset_out got %h exp 0", out); end
        op = 4'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_mult;
        int n; exp_t e;
        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        wait_done(n, e);
        checks++; if (n != 5) begin errors++; $display("FAIL mult_cycles got %0d exp 5", n); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
        checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL mult_sb got %h_%h exp %h_%h", hi, lo, e.hi, e.lo); end
        op = 4'd6; #1;
        checks++; if (out !== 32'hFFFFFFFA) begin errors++; $display("FAIL mflo got %h exp fffffffa", out); end
        op = 4'd0; #1;
        checks++; if (out !== 32'd0) begin errors++; $display("FAIL out_none got %h exp 0", out); end
    endtask

    task automatic test_multu_mfhi;
        int n; exp_t e;
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n, e);
        checks++; if (n != 5) begin errors++; $display("FAIL multu_cycles got %0d exp 5", n); end
        checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin errors++; $display("FAIL multu got %h_%h exp fffffffe_00000001", hi, lo); end
        checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL multu_sb got %h_%h exp %h_%h", hi, lo, e.hi, e.lo); end
        op = 4'd5; #1;
        checks++; if (out !== 32'hFFFFFFFE) begin errors++; $display("FAIL mfhi got %h exp fffffffe", out); end
        op = 4'd0;
    endtask

    task automatic test_div;
        int n; exp_t e;
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_done(n, e);
        checks++; if (n != 10) begin errors++; $display("FAIL div_cycles got %0d exp 10", n); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div got %h_%h exp ffffffff_fffffffd", hi, lo); end
        checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL div_sb got %h_%h exp %h_%h", hi, lo, e.hi, e.lo); end
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n, e);
        checks++; if (hi !== 32'h0 || lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h_%h exp 00000000_80000000", hi, lo); end
    endtask

    task automatic test_div_zero;
        int n; exp_t e;
        op = 4'd7; a = 32'h1234; tick();
        op = 4'd8; a = 32'h5678; tick();
        op = 4'd0; m_hi = 32'h1234; m_lo = 32'h5678;
        checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin errors++; $display("FAIL mthi_mtlo got %h_%h exp 00001234_00005678", hi, lo); end
        issue(4'd4, 32'd5, 32'd0);
        wait_done(n, e);
        checks++; if (n != 10) begin errors++; $display("FAIL divz_cycles got %0d exp 10", n); end
        checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin errors++; $display("FAIL divz got %h_%h exp 00001234_00005678", hi, lo); end
        checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL divz_sb got %h_%h exp %h_%h", hi, lo, e.hi, e.lo); end
    endtask

    task automatic test_ignored_busy;
        int k; exp_t e;
        logic [31:0] prev_lo;
        prev_lo = lo;
        issue(4'd1, 32'd7, 32'd6);
        op = 4'd6; #1;
        checks++; if (out !== prev_lo) begin errors++; $display("FAIL mflo_busy got %h exp %h", out, prev_lo); end
        op = 4'd0;
        tick();
        op = 4'd4; a = 32'd100; b = 32'd3; start = 1'b1; tick();
        start = 1'b0; op = 4'd8; a = 32'hAAAA; tick();
        op = 4'd0; a = 32'hFFFF; b = 32'hFFFF;
        wait_done(k, e);
        checks++; if (3 + k != 5) begin errors++; $display("FAIL ign_cycles got %0d exp 5", 3 + k); end
        checks++; if (hi !== 32'd0 || lo !== 32'd42) begin errors++; $display("FAIL ign_result got %h_%h exp 00000000_0000002a", hi, lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got %b exp 0", busy); end
    endtask

    task automatic test_invalid_start;
        op = 4'd5; start = 1'b1; tick();
        start = 1'b0; op = 4'd0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_start got %b exp 0", busy); end
        checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL bad_start_hl got %h_%h exp %h_%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_back_to_back;
        int n; exp_t e;
        logic [3:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 8; i++) begin
            o = 4'($urandom_range(1, 4));
            x = $urandom;
            y = (i == 5) ? 32'd0 : ((i % 2) ? $urandom_range(1, 300) : $urandom);
            issue(o, x, y);
            wait_done(n, e);
            checks++; if (n != ((o <= 4'd2) ? 5 : 10)) begin errors++; $display("FAIL b2b_cycles i=%0d op=%0d got %0d", i, o, n); end
            checks++; if (hi !== e.hi || lo !== e.lo) begin errors++; $display("FAIL b2b_res i=%0d op=%0d got %h_%h exp %h_%h", i, o, hi, lo, e.hi, e.lo); end
        end
    endtask

    task automatic test_reset_mid;
        issue(4'd3, 32'd100, 32'd7);
        tick(); tick(); tick();
        reset = 1'b1; #1;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_mid got busy=%b %h_%h exp 0 0_0", busy, hi, lo); end
        sb_q.delete(); m_hi = '0; m_lo = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_after c=%0d got busy=%b %h_%h exp 0 0_0", i, busy, hi, lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_mfhi();
        test_div();
        test_div_zero();
        test_ignored_busy();
        test_invalid_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving the busy duration of mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving the busy duration of div/divu.
REQ-003 The block SHALL have one clock and one reset, the reset being asynchronous and active-high.
REQ-004 Ports SHALL be as follows, one per line:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- E_MDUA  input  32  forwarded rs operand, the same value the E-stage ALU receives as E_ALUA.
- E_MDUB  input  32  forwarded rt operand, the same value the E-stage ALU receives as E_ALUB.
- E_MDUOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; codes 9-15 are treated as none.
- E_MDUStart  input  1  single-cycle qualifier for op codes 1-4.
- E_MDUBusy  output  1  high while an operation is in progress.
- E_MDUOut  output  32  read data for mfhi/mflo, muxed downstream with E_ALUAns.
- E_HI  output  32  architectural HI register.
- E_LO  output  32  architectural LO register.

Function
REQ-005 The state machine SHALL have exactly two states: IDLE and BUSY.
REQ-006 In IDLE, when E_MDUStart=1 and E_MDUOp is one of codes 1-4, the block SHALL latch E_MDUA, E_MDUB and E_MDUOp at the clock edge.
REQ-007 On that same edge the block SHALL load the cycle counter with MULT_CYCLES (codes 1-2) or DIV_CYCLES (codes 3-4) and enter BUSY.
REQ-008 E_MDUBusy SHALL be a registered output, equal to 1 exactly in BUSY.
- If start is sampled at edge t, busy is high for the N cycles following t.
REQ-009 The counter SHALL decrement once per cycle in BUSY.
- At the edge where the count reaches 1, HI/LO are written and the state returns to IDLE.
- The new HI/LO are visible in the same cycle that busy first reads 0.
REQ-010 mult SHALL compute the signed 64-bit product and multu the unsigned 64-bit product.
- HI receives bits [63:32] and LO receives bits [31:0].
REQ-011 div SHALL write the signed quotient to LO and the signed remainder to HI.
- The quotient truncates toward zero.
- The remainder takes the sign of the dividend.
REQ-012 divu SHALL write the unsigned quotient to LO and the unsigned remainder to HI.
REQ-013 For div and divu with a latched divisor of 0, HI and LO SHALL remain unchanged, with busy timing identical to a normal divide.
REQ-014 div of 0x80000000 by 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0x00000000.
REQ-015 The result SHALL depend only on the latched operands; changes on E_MDUA or E_MDUB during BUSY have no effect.
REQ-016 Writes from mthi and mtlo:
- In IDLE, mthi (7) writes E_MDUA to HI at the edge and mtlo (8) writes E_MDUA to LO at the edge.
- E_MDUStart is not required for these writes.
- The write is visible in the next cycle.
REQ-017 E_MDUOut SHALL be combinational: E_HI when op is 5, E_LO when op is 6, and 0 otherwise.
REQ-018 While BUSY, the block SHALL ignore E_MDUStart, mthi and mtlo.
- Upstream hazard logic is responsible for stalling these operations.
- E_MDUOut still reflects the current, not yet updated, HI/LO.
REQ-019 When E_MDUStart=1 with an op code outside 1-4, the block SHALL take no action and remain in IDLE.
REQ-020 The block SHALL have no back-to-back overlap: a new start is accepted no earlier than the first cycle in which busy reads 0.

Reset
REQ-021 Asserting reset SHALL immediately drive E_HI=0, E_LO=0, E_MDUBusy=0, state=IDLE, counter=0 and latched operands=0, without waiting for a clock edge.
REQ-022 Reset asserted mid-operation SHALL abort the operation, with no partial HI/LO update after reset is released.
REQ-023 The first start SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-024 mult test:
- Stimulus: mult with A=0xFFFFFFFE (-2) and B=3, started at edge t.
- Required: busy high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
- A follow-up mflo returns 0xFFFFFFFA.
REQ-025 multu and mfhi test:
- Stimulus: multu with A=0xFFFFFFFF and B=0xFFFFFFFF.
- Required: HI=0xFFFFFFFE and LO=0x00000001; mfhi returns 0xFFFFFFFE.
REQ-026 div test:
- Stimulus: div with A=0xFFFFFFF9 (-7) and B=2.
- Required: busy high for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-027 divide-by-zero test:
- Stimulus: mthi 0x1234 and mtlo 0x5678, then divu with A=5 and B=0.
- Required: busy high for 10 cycles; HI stays 0x1234 and LO stays 0x5678.
REQ-028 ignored-during-busy test:
- Stimulus: during cycle 3 of a mult, assert start with divu, then separately mtlo with 0xAAAA.
- Required: both are ignored, busy falls after exactly 5 cycles, and LO holds the mult result.
REQ-029 reset mid-operation test:
- Stimulus: assert reset in cycle 4 of a div.
- Required: busy, HI and LO read 0 immediately.
- Required: after reset release, no delayed result write occurs.
